// File: rtl/efuse_pkg.sv
// Shared definitions for the efuse program/verify controller.
package efuse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    PGM,
    VFY
  } state_t;

  localparam int M_DEF     = 32;
  localparam int WORDS_DEF = 4;
  localparam int T_PGM_DEF = 20;
  localparam int T_RD_DEF  = 5;

endpackage

// File: rtl/efuse_bit_seq.sv
// Bit index and per-bit slot timer shared by the READ, PGM and VFY phases.
module efuse_bit_seq #(
  parameter  int M     = 32,
  parameter  int T_PGM = 20,
  parameter  int T_RD  = 5,
  localparam int IW    = $clog2(M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          pgm,
  input  logic          cur_bit,
  output logic [IW-1:0] idx,
  output logic [M-1:0]  we,
  output logic          strobe,
  output logic          capture,
  output logic          word_end
);

  localparam int SLOT_MAX = (T_PGM + 2 > T_RD) ? T_PGM + 2 : T_RD;
  localparam int CW       = $clog2(SLOT_MAX);

  logic [CW-1:0] cnt;
  logic [CW-1:0] last;
  logic          slot_end;
  logic          bit_on;

  always_comb begin
    last     = pgm ? (cur_bit ? CW'(T_PGM + 1) : '0) : CW'(T_RD - 1);
    slot_end = run && (cnt == last);
    word_end = slot_end && (idx == IW'(M - 1));
    bit_on   = 1'b0;
    strobe   = 1'b0;
    capture  = 1'b0;
    if (run) begin
      if (pgm) begin
        // a zero bit occupies a single quiet cycle; a one bit selects, strobes, then rests
        bit_on = cur_bit && (cnt <= CW'(T_PGM));
        strobe = cur_bit && (cnt != '0) && (cnt <= CW'(T_PGM));
      end else begin
        bit_on  = cnt <= CW'(T_RD - 2);
        strobe  = (cnt == CW'(1)) || (cnt == CW'(2));
        capture = cnt == CW'(2);
      end
    end
    we = '0;
    if (bit_on) we[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (!run) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= word_end ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/efuse_pgm_verify_ctrl.sv
// Efuse word controller: read, program, and optional program-then-verify.
module efuse_pgm_verify_ctrl
  import efuse_pkg::*;
#(
  parameter  int M     = M_DEF,
  parameter  int WORDS = WORDS_DEF,
  parameter  int T_PGM = T_PGM_DEF,
  parameter  int T_RD  = T_RD_DEF,
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic             clk_div2,
  input  logic             rst,
  input  logic             rd,
  input  logic             wr,
  input  logic             vfy_en,
  input  logic [AW-1:0]    addr,
  input  logic [M-1:0]     data_in,
  input  logic             ack,
  input  logic             q,
  output logic             pgenb,
  output logic             nr,
  output logic             strobe,
  output logic [M-1:0]     we,
  output logic [WORDS-1:0] sel,
  output logic [M-1:0]     data_out,
  output logic             busy,
  output logic             rd_done,
  output logic             wr_done,
  output logic             vfy_err
);

  localparam int IW = $clog2(M);

  state_t          state;
  logic [M-1:0]    data_lat;
  logic [M-1:0]    rbuf;
  logic            vfy_lat;
  logic [IW-1:0]   idx;
  logic            capture;
  logic            word_end;

  efuse_bit_seq #(
    .M    (M),
    .T_PGM(T_PGM),
    .T_RD (T_RD)
  ) u_seq (
    .clk     (clk_div2),
    .rst     (rst),
    .run     (state != IDLE),
    .pgm     (state == PGM),
    .cur_bit (data_lat[idx]),
    .idx     (idx),
    .we      (we),
    .strobe  (strobe),
    .capture (capture),
    .word_end(word_end)
  );

  // Later assignments in this block override the ack clear, so a flag set wins.
  always_ff @(posedge clk_div2 or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      data_lat <= '0;
      rbuf     <= '0;
      vfy_lat  <= 1'b0;
      data_out <= '0;
      sel      <= '0;
      pgenb    <= 1'b1;
      nr       <= 1'b0;
      busy     <= 1'b0;
      rd_done  <= 1'b0;
      wr_done  <= 1'b0;
      vfy_err  <= 1'b0;
    end else begin
      if (ack) begin
        rd_done <= 1'b0;
        wr_done <= 1'b0;
        vfy_err <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (rd || wr) begin
            rd_done  <= 1'b0;
            wr_done  <= 1'b0;
            vfy_err  <= 1'b0;
            data_lat <= data_in;
            vfy_lat  <= vfy_en && !rd;
            rbuf     <= '0;
            if (32'(addr) >= 32'(WORDS)) begin
              rd_done <= rd;
              wr_done <= !rd;
              vfy_err <= 1'b1;
            end else begin
              state <= rd ? READ : PGM;
              pgenb <= rd;
              nr    <= rd;
              busy  <= 1'b1;
              sel   <= WORDS'(1) << addr;
            end
          end
        end
        PGM: begin
          if (word_end) begin
            if (vfy_lat) begin
              state <= VFY;
              pgenb <= 1'b1;
              nr    <= 1'b1;
            end else begin
              state   <= IDLE;
              pgenb   <= 1'b1;
              nr      <= 1'b0;
              busy    <= 1'b0;
              sel     <= '0;
              wr_done <= 1'b1;
            end
          end
        end
        READ, VFY: begin
          if (capture) rbuf[idx] <= q;
          if (word_end) begin
            data_out <= rbuf;
            state    <= IDLE;
            nr       <= 1'b0;
            busy     <= 1'b0;
            sel      <= '0;
            if (state == READ) begin
              rd_done <= 1'b1;
            end else begin
              wr_done <= 1'b1;
              vfy_err <= |(data_lat & ~rbuf);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_efuse_pgm_verify_ctrl.sv
// Bench for efuse_pgm_verify_ctrl: efuse array model, cycle trace reference, directed and random traffic.
module tb_efuse_pgm_verify_ctrl;

  localparam int M     = 8;
  localparam int WORDS = 4;
  localparam int T_PGM = 20;
  localparam int T_RD  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd = 1'b0, wr = 1'b0, vfy_en = 1'b0, ack = 1'b0;
  logic [1:0] addr = '0;
  logic [7:0] data_in = '0;
  logic       q;
  logic       pgenb, nr, strobe, busy, rd_done, wr_done, vfy_err;
  logic [7:0] we, data_out;
  logic [3:0] sel;

  int n_checks = 0;
  int n_fail   = 0;

  efuse_pgm_verify_ctrl #(
    .M    (M),
    .WORDS(WORDS),
    .T_PGM(T_PGM),
    .T_RD (T_RD)
  ) dut (
    .clk_div2(clk),
    .rst     (rst),
    .rd      (rd),
    .wr      (wr),
    .vfy_en  (vfy_en),
    .addr    (addr),
    .data_in (data_in),
    .ack     (ack),
    .q       (q),
    .pgenb   (pgenb),
    .nr      (nr),
    .strobe  (strobe),
    .we      (we),
    .sel     (sel),
    .data_out(data_out),
    .busy    (busy),
    .rd_done (rd_done),
    .wr_done (wr_done),
    .vfy_err (vfy_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Physical efuse array: a bit blows only after a full T_PGM strobe with pgenb low.
  logic [7:0] fuse_phys [4] = '{8'h00, 8'h00, 8'hA5, 8'h00};
  logic [7:0] stuck     [4] = '{8'h00, 8'h04, 8'h00, 8'h00};
  int pcnt = 0;

  always_comb begin
    q = 1'b0;
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 8; b++)
        if (nr && strobe && sel[w] && we[b]) q = fuse_phys[w][b];
  end

  always @(posedge clk) begin
    if (!pgenb && strobe && $onehot(we) && $onehot(sel)) begin
      pcnt++;
      if (pcnt == T_PGM)
        for (int w = 0; w < 4; w++)
          for (int b = 0; b < 8; b++)
            if (sel[w] && we[b] && !stuck[w][b]) fuse_phys[w][b] = 1'b1;
    end else begin
      pcnt = 0;
    end
  end

  // Reference: expected output waveform per cycle, built from the protocol rules at acceptance.
  typedef struct packed {
    logic       pgenb;
    logic       nr;
    logic       strobe;
    logic [7:0] we;
    logic [3:0] sel;
    logic       busy;
  } cyc_t;

  cyc_t       exp_q[$];
  logic [7:0] fuse_ref [4] = '{8'h00, 8'h00, 8'hA5, 8'h00};
  logic       m_rd_done = 1'b0, m_wr_done = 1'b0, m_vfy_err = 1'b0;
  logic [7:0] m_dout = '0;
  logic       pending = 1'b0, p_rd = 1'b0, p_upd = 1'b0, p_err = 1'b0;
  logic [7:0] p_dout = '0, p_word = '0;
  logic [1:0] p_addr = '0;

  task automatic push(input logic pg, input logic n, input logic st, input logic [7:0] w, input logic [3:0] s);
    cyc_t c;
    c = '{pgenb: pg, nr: n, strobe: st, we: w, sel: s, busy: 1'b1};
    exp_q.push_back(c);
  endtask

  task automatic push_read(input logic [3:0] s);
    for (int i = 0; i < M; i++)
      for (int c = 0; c < T_RD; c++)
        push(1'b1, 1'b1, (c == 1) || (c == 2), (c <= T_RD - 2) ? 8'(1 << i) : 8'h00, s);
  endtask

  task automatic push_pgm(input logic [7:0] d, input logic [3:0] s);
    for (int i = 0; i < M; i++) begin
      if (d[i]) begin
        push(1'b0, 1'b0, 1'b0, 8'(1 << i), s);
        for (int k = 0; k < T_PGM; k++) push(1'b0, 1'b0, 1'b1, 8'(1 << i), s);
      end
      push(1'b0, 1'b0, 1'b0, 8'h00, s);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      pending   = 1'b0;
      m_rd_done = 1'b0;
      m_wr_done = 1'b0;
      m_vfy_err = 1'b0;
      m_dout    = '0;
    end else begin
      if (ack) begin
        m_rd_done = 1'b0;
        m_wr_done = 1'b0;
        m_vfy_err = 1'b0;
      end
      if (pending) begin
        if (exp_q.size() == 0) begin
          pending = 1'b0;
          if (!p_rd) fuse_ref[p_addr] = p_word;
          if (p_upd) m_dout = p_dout;
          if (p_rd) m_rd_done = 1'b1;
          else begin
            m_wr_done = 1'b1;
            m_vfy_err = p_err;
          end
        end
      end else if (rd || wr) begin
        m_rd_done = 1'b0;
        m_wr_done = 1'b0;
        m_vfy_err = 1'b0;
        pending   = 1'b1;
        p_addr    = addr;
        p_rd      = rd;
        if (rd) begin
          push_read(4'(1 << addr));
          p_upd  = 1'b1;
          p_dout = fuse_ref[addr];
          p_err  = 1'b0;
        end else begin
          push_pgm(data_in, 4'(1 << addr));
          p_word = fuse_ref[addr] | (data_in & ~stuck[addr]);
          p_upd  = vfy_en;
          p_dout = p_word;
          p_err  = vfy_en && ((data_in & ~p_word) != 8'h00);
          if (vfy_en) push_read(4'(1 << addr));
        end
      end
    end
  end

  always @(negedge clk) begin
    cyc_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{pgenb: 1'b1, nr: 1'b0, strobe: 1'b0, we: 8'h00, sel: 4'h0, busy: 1'b0};
    check("pgenb", pgenb, e.pgenb);
    check("nr", nr, e.nr);
    check("strobe", strobe, e.strobe);
    check("we", we, e.we);
    check("sel", sel, e.sel);
    check("busy", busy, e.busy);
    check("data_out", data_out, m_dout);
    check("rd_done", rd_done, m_rd_done);
    check("wr_done", wr_done, m_wr_done);
    check("vfy_err", vfy_err, m_vfy_err);
  end

  task automatic run_txn(input logic r, input logic w, input logic v, input logic [1:0] a,
                         input logic [7:0] d, output int cyc, output int pulses, output int hi,
                         output logic pg_low, output logic pg_high, output logic [3:0] sel0);
    logic prev;
    @(posedge clk); #1;
    rd = r; wr = w; vfy_en = v; addr = a; data_in = d;
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    cyc = 0; pulses = 0; hi = 0; pg_low = 1'b0; pg_high = 1'b0; prev = 1'b0;
    sel0 = sel;
    while (busy && cyc < 2000) begin
      if (strobe && !prev) pulses++;
      if (strobe) hi++;
      prev = strobe;
      if (!pgenb) pg_low = 1'b1;
      else pg_high = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 2000) check("txn_timeout", 32'(cyc), 32'd0);
  endtask

  initial begin
    int cyc, pulses, hi, k;
    logic pg_low, pg_high;
    logic [3:0] sel0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 8'h00);
    check("rst_pgenb", pgenb, 1'b1);
    check("rst_nr", nr, 1'b0);
    check("rst_strobe", strobe, 1'b0);
    check("rst_we", we, 8'h00);
    check("rst_sel", sel, 4'h0);
    check("rst_flags", {busy, rd_done, wr_done, vfy_err}, 4'h0);
    rst = 1'b0;

    run_txn(1'b1, 1'b0, 1'b0, 2'd2, 8'h00, cyc, pulses, hi, pg_low, pg_high, sel0);
    check("read_sel", sel0, 4'b0100);
    check("read_cycles", 32'(cyc), 32'd40);
    check("read_pulses", 32'(pulses), 32'd8);
    check("read_strobe_cycles", 32'(hi), 32'd16);
    check("read_data", data_out, 8'hA5);
    check("read_done", rd_done, 1'b1);

    run_txn(1'b0, 1'b1, 1'b0, 2'd0, 8'h81, cyc, pulses, hi, pg_low, pg_high, sel0);
    check("pgm_cycles", 32'(cyc), 32'd50);
    check("pgm_pulses", 32'(pulses), 32'd2);
    check("pgm_strobe_cycles", 32'(hi), 32'd40);
    check("pgm_pgenb_high_seen", pg_high, 1'b0);
    check("pgm_done", {wr_done, vfy_err}, 2'b10);

    run_txn(1'b0, 1'b1, 1'b1, 2'd1, 8'h0F, cyc, pulses, hi, pg_low, pg_high, sel0);
    check("vfy_cycles", 32'(cyc), 32'd132);
    check("vfy_data", data_out, 8'h0B);
    check("vfy_flags", {rd_done, wr_done, vfy_err}, 3'b011);
    @(posedge clk); #1; ack = 1'b1;
    @(posedge clk); #1; ack = 1'b0;
    check("ack_clear", {rd_done, wr_done, vfy_err}, 3'b000);

    run_txn(1'b1, 1'b1, 1'b1, 2'd0, 8'hFF, cyc, pulses, hi, pg_low, pg_high, sel0);
    check("coll_cycles", 32'(cyc), 32'd40);
    check("coll_pgenb_low_seen", pg_low, 1'b0);
    check("coll_data", data_out, 8'h81);
    check("coll_flags", {rd_done, wr_done}, 2'b10);

    run_txn(1'b0, 1'b1, 1'b0, 2'd3, 8'h00, cyc, pulses, hi, pg_low, pg_high, sel0);
    check("noop_cycles", 32'(cyc), 32'd8);
    check("noop_strobes", 32'(hi), 32'd0);
    check("noop_done", wr_done, 1'b1);

    @(posedge clk); #1;
    wr = 1'b1; vfy_en = 1'b0; addr = 2'd3; data_in = 8'h10;
    @(posedge clk); #1;
    wr = 1'b0;
    k = 0;
    while (!strobe && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("rstpgm_strobe_seen", strobe, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rstpgm_strobe", strobe, 1'b0);
    check("rstpgm_we", we, 8'h00);
    check("rstpgm_pgenb", pgenb, 1'b1);
    check("rstpgm_busy", busy, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstpgm_no_done", wr_done, 1'b0);
    run_txn(1'b1, 1'b0, 1'b0, 2'd3, 8'h00, cyc, pulses, hi, pg_low, pg_high, sel0);
    check("rstpgm_read_cycles", 32'(cyc), 32'd40);
    check("rstpgm_read_data", data_out, 8'h00);
    check("rstpgm_read_done", rd_done, 1'b1);

    for (int n = 0; n < 2500; n++) begin
      @(posedge clk); #1;
      rd      = ($urandom % 25) == 0;
      wr      = ($urandom % 18) == 0;
      ack     = ($urandom % 12) == 0;
      vfy_en  = $urandom_range(0, 1) == 1;
      addr    = 2'($urandom % 4);
      data_in = 8'($urandom & $urandom & $urandom);
    end
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0; ack = 1'b0;
    k = 0;
    while (busy && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_idle", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
